// File: rtl/mem_read_arbiter_if.sv
// mem_read_arbiter_if
//   Bundles the two requester channels (fetch, load) and the memory read port
//   that meet at mem_read_arbiter.
//
//   Handshake: a requester raises *Req with a stable *Addr and holds both
//   until *Grant is 1 in the same cycle. Req+Grant high in a cycle means the
//   read was issued. Dropping Req before the grant withdraws the request.
//   The requester may request again in the cycle after a grant.
//   Responses come back as *Valid/*Data for exactly one cycle and have no
//   backpressure, so the requester must take the data in that cycle.
//
//   modport slave  : arbiter side (takes requests, drives grants/responses/memory)
//   modport master : requester + memory side (testbench / core / memory model)
interface mem_read_arbiter_if #(
  parameter int ADDR_W = 61,
  parameter int DATA_W = 64
);
  logic              fetchReq;
  logic [ADDR_W-1:0] fetchAddr;
  logic              fetchGrant;
  logic              fetchValid;
  logic [DATA_W-1:0] fetchData;

  logic              loadReq;
  logic [ADDR_W-1:0] loadAddr;
  logic              loadGrant;
  logic              loadValid;
  logic [DATA_W-1:0] loadData;

  logic              memReadEn;
  logic [ADDR_W-1:0] memReadAddr;
  logic [DATA_W-1:0] memReadData;

  modport slave (
    input  fetchReq, fetchAddr, loadReq, loadAddr, memReadData,
    output fetchGrant, fetchValid, fetchData,
    output loadGrant, loadValid, loadData,
    output memReadEn, memReadAddr
  );

  modport master (
    output fetchReq, fetchAddr, loadReq, loadAddr, memReadData,
    input  fetchGrant, fetchValid, fetchData,
    input  loadGrant, loadValid, loadData,
    input  memReadEn, memReadAddr
  );
endinterface

// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter
//   Shares the single memory read port between instruction fetch and loads.
//   Load wins contention unless fetch has been denied STARVE_MAX consecutive
//   cycles. In-flight reads are tracked by a LATENCY-deep {valid,isLoad} tag
//   pipeline, so each response is routed back to the requester that issued it.
//
//   Ports:
//     clk     : rising-edge clock
//     reset_n : asynchronous active-low reset
//     bus     : mem_read_arbiter_if.slave (fetch/load channels + memory read port)
module mem_read_arbiter #(
  parameter int LATENCY    = 1,
  parameter int STARVE_MAX = 3,
  parameter int ADDR_W     = 61,
  parameter int DATA_W     = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  mem_read_arbiter_if.slave  bus
);

  logic [3:0]         starve_q, starve_d;
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [LATENCY-1:0] is_ld_q, is_ld_d;

  logic starved;
  logic fetch_win;
  logic fetch_grant;
  logic load_grant;
  logic mem_read_en;
  logic out_valid;
  logic out_is_ld;

  // Arbitration is purely combinational so a request is granted in the cycle
  // it is presented. Grants are gated by reset_n so nothing issues in reset.
  assign starved     = (starve_q == 4'(STARVE_MAX));
  assign fetch_win   = bus.fetchReq & (~bus.loadReq | starved);
  assign fetch_grant = reset_n & fetch_win;
  assign load_grant  = reset_n & bus.loadReq & ~fetch_win;
  assign mem_read_en = fetch_grant | load_grant;

  assign bus.fetchGrant = fetch_grant;
  assign bus.loadGrant  = load_grant;
  assign bus.memReadEn  = mem_read_en;

  always_comb begin
    bus.memReadAddr = {ADDR_W{1'b0}};
    if (fetch_grant) begin
      bus.memReadAddr = bus.fetchAddr;
    end else if (load_grant) begin
      bus.memReadAddr = bus.loadAddr;
    end
  end

  // Consecutive-denial counter: any cycle where fetch is not waiting (or has
  // just been served) restarts the count; it saturates at STARVE_MAX.
  always_comb begin
    starve_d = starve_q;
    if (!bus.fetchReq || fetch_grant) begin
      starve_d = 4'd0;
    end else if (!starved) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // Tag pipeline: bit 0 takes this cycle's issue, higher bits age by one edge,
  // so the top bit lines up with memReadData of the matching read.
  assign vld_d   = (vld_q << 1)   | LATENCY'(mem_read_en);
  assign is_ld_d = (is_ld_q << 1) | LATENCY'(load_grant);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_q <= 4'd0;
      vld_q    <= '0;
      is_ld_q  <= '0;
    end else begin
      starve_q <= starve_d;
      vld_q    <= vld_d;
      is_ld_q  <= is_ld_d;
    end
  end

  assign out_valid = vld_q[LATENCY-1];
  assign out_is_ld = is_ld_q[LATENCY-1];

  assign bus.fetchValid = out_valid & ~out_is_ld;
  assign bus.loadValid  = out_valid & out_is_ld;
  assign bus.fetchData  = bus.fetchValid ? bus.memReadData : {DATA_W{1'b0}};
  assign bus.loadData   = bus.loadValid  ? bus.memReadData : {DATA_W{1'b0}};

endmodule
